alu_arbiter: RTL

Shares one combinational ALU between two requesters (e.g. EX-stage operand path and a branch/compare helper) using round-robin arbitration and valid/ready handshakes. It latches the granted operands, evaluates them in one cycle and holds a tagged result until it is consumed. It sits between the requesting pipeline logic and a single instance of the team's `alu`.

---
 rtl/alu_arbiter_pkg.sv | 16 +
 rtl/alu_arbiter_alu.sv | 29 ++
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU control encoding for alu_arbiter
// Purpose: ALU control constants used by the arbiter and its ALU instance.
// Ports: none (package).
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_EQ  = 3'd3;

  // Encodings above ALU_EQ are reserved; the ALU returns 0 for them.
  function automatic logic ctr_invalid(input logic [2:0] ctr);
    return (ctr > ALU_EQ);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU shared by the arbiter
// Purpose: add/sub (wrapping), bitwise or, equality compare.
// Ports:
//   i_a, i_b  operands
//   i_ctr     operation select (ALU_ADD/SUB/OR/EQ, others give 0)
//   o_result  result
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_ctr,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_ctr)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_EQ:  o_result = {{(DATA_W-1){1'b0}}, (i_a == i_b)};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
// Purpose: grants one requester at a time, latches its operands, evaluates
// them in one cycle and holds the tagged result until consumed.
// Ports:
//   clk, reset                 clock, async active-high reset
//   r0_*/r1_*                  requester valid/ready handshake, operands, ctr
//   rsp_valid/rsp_ready        response handshake
//   rsp_id, rsp_data, rsp_err  response owner, result, invalid-ctr flag
//   busy                       FSM not idle
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [2:0]        r0_ctr,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [2:0]        r1_ctr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_prio;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [2:0]          r_op_ctr;
  logic                r_op_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_id;
  logic                r_rsp_err;
  logic                w_grant;
  logic                w_grant_id;
  logic [DATA_W-1:0]   w_alu_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Readies are forced low during reset so nothing can look granted while
  // the state register is being held.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_grant_id   = 1'b0;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!reset) begin
          // r0 wins if alone or if it holds priority; otherwise r1 if present.
          if (r0_valid && (!r1_valid || !r_prio)) begin
            r0_ready   = 1'b1;
            w_grant    = 1'b1;
            w_grant_id = 1'b0;
          end else if (r1_valid) begin
            r1_ready   = 1'b1;
            w_grant    = 1'b1;
            w_grant_id = 1'b1;
          end
        end
        if (w_grant) begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: w_next_state = ST_DONE;
      ST_DONE: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio     <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_ctr   <= '0;
      r_op_id    <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_id   <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_op_a   <= w_grant_id ? r1_a   : r0_a;
        r_op_b   <= w_grant_id ? r1_b   : r0_b;
        r_op_ctr <= w_grant_id ? r1_ctr : r0_ctr;
        r_op_id  <= w_grant_id;
        r_prio   <= ~w_grant_id;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= w_alu_result;
        r_rsp_id   <= r_op_id;
        r_rsp_err  <= ctr_invalid(r_op_ctr);
      end
    end
  end

  alu_arbiter_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .i_ctr    (r_op_ctr),
    .o_result (w_alu_result)
  );

  assign rsp_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;

endmodule
